// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_arb_pkg
// Brief    : Shared FSM encoding and rotating-priority pick for DDR arbiters.
// Revision : 1.0
// ============================================================================
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 3;
    localparam int MAX_REQ   = 8;

    // Walk downward so the lowest rotated offset from ptr overwrites last and wins.
    function automatic logic [MAX_REQ-1:0] rr_onehot(input logic [MAX_REQ-1:0] req,
                                                     input int ptr,
                                                     input int n);
        logic [MAX_REQ-1:0] oh;
        int                 idx;
        logic [2:0]         idx3;
        oh = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx  = (ptr + k) % n;
                idx3 = idx[2:0];
                if (req[idx3]) begin
                    oh = MAX_REQ'(1) << idx3;
                end
            end
        end
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotating-priority encoder (one-hot winner + index).
// Revision : 1.0
// ============================================================================
module rr_pick
    import ddr_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_oh_ext;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[N_REQ-1:0]   = i_req;
        w_oh_ext               = rr_onehot(w_req_ext, int'(i_ptr), N_REQ);
        o_gnt                  = w_oh_ext[N_REQ-1:0];
        o_valid                = |w_oh_ext;
        o_idx                  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_oh_ext[i]) begin
                o_idx = PTR_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rd_arbiter
// Brief    : Round-robin arbiter for one DDR read channel; optional watchdog
//            enabled by DDR_RD_ARB_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module ddr_rd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int DQ_WIDTH   = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                        ddr_clk,
    input  logic                        ddr_rstn,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            gnt_rdata_en,
    output logic [N_REQ-1:0]            gnt_rdone,
    output logic                        ddr_rd_req,
    output logic [ADDR_WIDTH-1:0]       ddr_raddr,
    output logic [LEN_WIDTH-1:0]        ddr_rd_len,
    input  logic                        ddr_rd_ack,
    input  logic                        ddr_rdata_en,
    input  logic                        ddr_rdone,
    output logic                        arb_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                  r_state;
    state_t                  w_next;
    logic [N_REQ-1:0]        r_gnt;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_idx;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [LEN_WIDTH-1:0]    r_len;
    logic                    r_rd_req;
    logic [N_REQ-1:0]        w_pick_gnt;
    logic [PTR_W-1:0]        w_pick_idx;
    logic                    w_pick_valid;
    logic                    w_grant;
    logic                    w_release;
    logic                    w_wd_fire;
    logic [PTR_W-1:0]        w_ptr_nxt;

    // Elaboration-only marker for configurations outside the supported range.
    if ((DQ_WIDTH < 1) || (TIMEOUT < 2)) begin : g_cfg_unsupported
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_release = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant = 1'b1;
                    w_next  = ST_REQ;
                end
            end
            ST_REQ: begin
                // Done coincident with ack completes the burst in one step.
                if (w_wd_fire || (ddr_rd_ack && ddr_rdone)) begin
                    w_release = 1'b1;
                    w_next    = ST_IDLE;
                end else if (ddr_rd_ack) begin
                    w_next    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_wd_fire || ddr_rdone) begin
                    w_release = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_ptr_nxt = (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            r_gnt    <= '0;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_raddr  <= '0;
            r_len    <= '0;
            r_rd_req <= 1'b0;
        end else begin
            r_rd_req <= (r_state == ST_REQ) && (w_next == ST_REQ);
            if (w_grant) begin
                r_gnt   <= w_pick_gnt;
                r_idx   <= w_pick_idx;
                r_raddr <= req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                r_len   <= req_len[int'(w_pick_idx)*LEN_WIDTH +: LEN_WIDTH];
            end else if (w_release) begin
                r_gnt <= '0;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef DDR_RD_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_arb_err;

    assign w_wd_fire = (r_state != ST_IDLE) && (r_wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            r_wd_cnt  <= '0;
            r_arb_err <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_wd_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_fire) begin
                r_arb_err <= 1'b1;
            end
        end
    end

    assign arb_err = r_arb_err;
`else
    assign w_wd_fire = 1'b0;
    assign arb_err   = 1'b0;
`endif

    assign gnt          = r_gnt;
    assign ddr_rd_req   = r_rd_req;
    assign ddr_raddr    = r_raddr;
    assign ddr_rd_len   = r_len;
    assign gnt_rdone    = w_release ? r_gnt : '0;
    assign gnt_rdata_en = ((r_state == ST_BUSY) && ddr_rdata_en) ? r_gnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_rd_arbiter
// Brief    : Directed self-checking bench for ddr_rd_arbiter.
// Revision : 1.0
// ============================================================================
module tb_ddr_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 27;
    localparam int LW = 16;
    localparam int DW = 32;
`ifdef DDR_RD_ARB_WATCHDOG_EN
    localparam int TO = 64;
`else
    localparam int TO = 4096;
`endif

    logic            ddr_clk = 1'b0;
    logic            ddr_rstn;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic [N-1:0]    gnt_rdata_en;
    logic [N-1:0]    gnt_rdone;
    logic            ddr_rd_req;
    logic [AW-1:0]   ddr_raddr;
    logic [LW-1:0]   ddr_rd_len;
    logic            ddr_rd_ack;
    logic            ddr_rdata_en;
    logic            ddr_rdone;
    logic            arb_err;

    int n_tests = 0;
    int n_fail  = 0;

    ddr_rd_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .DQ_WIDTH   (DW),
        .TIMEOUT    (TO)
    ) dut (
        .ddr_clk      (ddr_clk),
        .ddr_rstn     (ddr_rstn),
        .req          (req),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .gnt          (gnt),
        .gnt_rdata_en (gnt_rdata_en),
        .gnt_rdone    (gnt_rdone),
        .ddr_rd_req   (ddr_rd_req),
        .ddr_raddr    (ddr_raddr),
        .ddr_rd_len   (ddr_rd_len),
        .ddr_rd_ack   (ddr_rd_ack),
        .ddr_rdata_en (ddr_rdata_en),
        .ddr_rdone    (ddr_rdone),
        .arb_err      (arb_err)
    );

    always #5 ddr_clk = ~ddr_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
    endtask

    task automatic do_reset();
        cyc();
        ddr_rstn = 1'b0;
        cyc();
        cyc();
        ddr_rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int beats;
        logic gnt_bad;

        ddr_rstn     = 1'b0;
        req          = '0;
        req_addr     = '0;
        req_len      = '0;
        ddr_rd_ack   = 1'b0;
        ddr_rdata_en = 1'b0;
        ddr_rdone    = 1'b0;
        #12;
        check("rst_gnt",    64'(gnt),        64'h0);
        check("rst_rd_req", 64'(ddr_rd_req), 64'h0);
        check("rst_raddr",  64'(ddr_raddr),  64'h0);
        check("rst_len",    64'(ddr_rd_len), 64'h0);
        check("rst_rdone",  64'(gnt_rdone),  64'h0);
        check("rst_err",    64'(arb_err),    64'h0);
        cyc();
        ddr_rstn = 1'b1;

        // Single requester 1: cycle 0 raises req.
        cyc();
        set_slot(0, 27'h0AA_A000, 16'd5);
        set_slot(1, 27'h000_1000, 16'd16);
        set_slot(2, 27'h155_5000, 16'd9);
        req = 3'b010;
        #1 check("t1_c0_rd_req", 64'(ddr_rd_req), 64'h0);
        cyc();
        check("t1_c1_gnt",    64'(gnt),        64'h2);
        check("t1_c1_rd_req", 64'(ddr_rd_req), 64'h0);
        check("t1_raddr",     64'(ddr_raddr),  64'h1000);
        check("t1_len",       64'(ddr_rd_len), 64'd16);
        cyc();
        check("t1_c2_rd_req", 64'(ddr_rd_req), 64'h1);
        cyc();
        cyc();
        ddr_rd_ack = 1'b1;
        cyc();
        ddr_rd_ack = 1'b0;
        req        = 3'b000;
        #1 check("t1_c5_rd_req", 64'(ddr_rd_req), 64'h0);
        beats   = 0;
        gnt_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ddr_rdata_en = 1'b1;
            #1;
            if (gnt_rdata_en == 3'b010) beats++;
            if (gnt != 3'b010) gnt_bad = 1'b1;
            cyc();
        end
        ddr_rdata_en = 1'b0;
        check("t1_beats",    64'(beats),   64'd16);
        check("t1_gnt_hold", 64'(gnt_bad), 64'h0);
        ddr_rdone = 1'b1;
        #1 check("t1_rdone", 64'(gnt_rdone), 64'h2);
        cyc();
        ddr_rdone = 1'b0;
        #1 check("t1_rdone_once", 64'(gnt_rdone), 64'h0);
        cyc();
        check("t1_idle_gnt", 64'(gnt), 64'h0);

        // Three continuous requesters from a fresh pointer.
        do_reset();
        req = 3'b111;
        for (int b = 0; b < 6; b++) begin
            cyc();
            check($sformatf("t2_gnt_%0d", b), 64'(gnt), 64'(3'b001 << (b % 3)));
            cyc();
            check($sformatf("t2_rd_req_%0d", b), 64'(ddr_rd_req), 64'h1);
            ddr_rd_ack = 1'b1;
            cyc();
            ddr_rd_ack   = 1'b0;
            ddr_rdata_en = 1'b1;
            #1 check($sformatf("t2_rdata_%0d", b), 64'(gnt_rdata_en), 64'(3'b001 << (b % 3)));
            cyc();
            ddr_rdata_en = 1'b0;
            ddr_rdone    = 1'b1;
            #1 check($sformatf("t2_rdone_%0d", b), 64'(gnt_rdone), 64'(3'b001 << (b % 3)));
            cyc();
            ddr_rdone = 1'b0;
            check($sformatf("t2_gap_%0d", b), 64'(gnt), 64'h0);
        end
        req = 3'b000;

        // Address change and req drop mid-burst (ptr=0).
        cyc();
        set_slot(1, 27'h002_3450, 16'd8);
        req = 3'b010;
        cyc();
        check("t3_raddr", 64'(ddr_raddr), 64'h23450);
        cyc();
        ddr_rd_ack = 1'b1;
        cyc();
        ddr_rd_ack   = 1'b0;
        set_slot(1, 27'h7FF_FFFF, 16'hFFFF);
        req          = 3'b000;
        ddr_rdata_en = 1'b1;
        #1 check("t3_rdata", 64'(gnt_rdata_en), 64'h2);
        cyc();
        ddr_rdata_en = 1'b0;
        ddr_rdone    = 1'b1;
        #1 check("t3_rdone", 64'(gnt_rdone), 64'h2);
        check("t3_raddr_hold", 64'(ddr_raddr), 64'h23450);
        cyc();
        ddr_rdone = 1'b0;
        check("t3_gnt_clr", 64'(gnt), 64'h0);

        // Spurious done/data in IDLE, then in REQ, then ack coincident with done (ptr=2).
        ddr_rdone    = 1'b1;
        ddr_rdata_en = 1'b1;
        #1 check("t4_idle_rdone", 64'(gnt_rdone),    64'h0);
        check("t4_idle_rdata",    64'(gnt_rdata_en), 64'h0);
        cyc();
        check("t4_idle_gnt", 64'(gnt), 64'h0);
        ddr_rdone    = 1'b0;
        ddr_rdata_en = 1'b0;
        req          = 3'b001;
        cyc();
        check("t4_gnt", 64'(gnt), 64'h1);
        ddr_rdone    = 1'b1;
        ddr_rdata_en = 1'b1;
        #1 check("t4_req_rdone", 64'(gnt_rdone),    64'h0);
        check("t4_req_rdata",    64'(gnt_rdata_en), 64'h0);
        cyc();
        check("t4_req_hold", 64'(gnt), 64'h1);
        ddr_rdata_en = 1'b0;
        ddr_rd_ack   = 1'b1;
        #1 check("t4_ack_done", 64'(gnt_rdone), 64'h1);
        cyc();
        ddr_rd_ack = 1'b0;
        ddr_rdone  = 1'b0;
        req        = 3'b000;
        check("t4_back_idle", 64'(gnt), 64'h0);

        // Asynchronous reset in BUSY (ptr=1, winner 2).
        req = 3'b100;
        cyc();
        cyc();
        ddr_rd_ack = 1'b1;
        cyc();
        ddr_rd_ack = 1'b0;
        req        = 3'b000;
        check("t5_busy_gnt", 64'(gnt), 64'h4);
        #1 ddr_rstn = 1'b0;
        #1 check("t5_async_gnt", 64'(gnt),        64'h0);
        check("t5_async_raddr",  64'(ddr_raddr),  64'h0);
        check("t5_async_len",    64'(ddr_rd_len), 64'h0);
        cyc();
        cyc();
        ddr_rstn = 1'b1;
        req      = 3'b011;
        cyc();
        check("t5_ptr_reset", 64'(gnt), 64'h1);
        req = 3'b000;
        cyc();
        ddr_rd_ack = 1'b1;
        ddr_rdone  = 1'b1;
        cyc();
        ddr_rd_ack = 1'b0;
        ddr_rdone  = 1'b0;

`ifdef DDR_RD_ARB_WATCHDOG_EN
        // Controller never acks: watchdog releases after TO cycles (ptr=1).
        req = 3'b010;
        cyc();
        check("t6_gnt", 64'(gnt), 64'h2);
        for (int i = 0; i < TO - 1; i++) cyc();
        check("t6_wd_rdone",  64'(gnt_rdone), 64'h2);
        check("t6_err_early", 64'(arb_err),   64'h0);
        cyc();
        check("t6_err_set",   64'(arb_err), 64'h1);
        check("t6_gnt_clr",   64'(gnt),     64'h0);
        req = 3'b110;
        cyc();
        check("t6_ptr_adv", 64'(gnt), 64'h4);
        req = 3'b000;
        cyc();
        ddr_rd_ack = 1'b1;
        ddr_rdone  = 1'b1;
        cyc();
        ddr_rd_ack = 1'b0;
        ddr_rdone  = 1'b0;
        check("t6_err_sticky", 64'(arb_err), 64'h1);
`else
        // Without the watchdog a hung controller holds the grant (ptr=1).
        req = 3'b010;
        cyc();
        for (int i = 0; i < 100; i++) cyc();
        check("t6_hang_gnt",    64'(gnt),        64'h2);
        check("t6_hang_rd_req", 64'(ddr_rd_req), 64'h1);
        check("t6_no_err",      64'(arb_err),    64'h0);
        req        = 3'b000;
        ddr_rd_ack = 1'b1;
        ddr_rdone  = 1'b1;
        #1 check("t6_hang_rdone", 64'(gnt_rdone), 64'h2);
        cyc();
        ddr_rd_ack = 1'b0;
        ddr_rdone  = 1'b0;
`endif
        cyc();
        check("end_gnt", 64'(gnt), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
